// File: rtl/joy_serial_scanner.sv
`default_nettype none
// ============================================================================
// Module      : joy_serial_scanner
// Description : Scans two DB9 joysticks through an external 16-bit
//               parallel-in/serial-out shift register. Generates the load
//               strobe and shift clock, captures one 16-bit frame per scan
//               and publishes joystick state only after two consecutive
//               identical frames (glitch filter).
// Revision    : 1.0 - initial release
// ============================================================================
module joy_serial_scanner #(
    parameter int CLKDIV = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       joy_data,
    output logic       joy_load_n,
    output logic       joy_clk,
    output logic [5:0] db9joy1_out,
    output logic [5:0] db9joy2_out,
    output logic       frame_done,
    output logic       busy
);

    localparam logic [7:0] c_TICK_LAST = 8'(CLKDIV - 1);
    localparam logic [3:0] c_BIT_LAST  = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SAMPLE = 3'd2,
        S_CLKHI  = 3'd3,
        S_UPDATE = 3'd4
    } state_t;

    state_t      r_state;
    logic [7:0]  r_tick_cnt;
    logic [3:0]  r_bit_cnt;
    logic [15:0] r_shift;
    logic [11:0] r_prev_frame;
    logic [1:0]  r_sync;
    logic        w_tick;
    logic        w_data_s;
    logic [11:0] w_frame;

    assign w_tick   = (r_tick_cnt == c_TICK_LAST);
    assign w_data_s = r_sync[1];
    // Only the twelve bits carrying joystick buttons take part in filtering
    assign w_frame  = {r_shift[15:10], r_shift[7:2]};

    // Free-running divider; every phase of the scan lasts one full period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= 8'd0;
        end else if (w_tick) begin
            r_tick_cnt <= 8'd0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 8'd1;
        end
    end

    // Two-flop synchroniser for the asynchronous serial input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], joy_data};
        end
    end

    // Scan sequencer with all outputs registered on state transitions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_bit_cnt    <= 4'd0;
            r_shift      <= 16'hFFFF;
            r_prev_frame <= 12'hFFF;
            joy_load_n   <= 1'b1;
            joy_clk      <= 1'b0;
            db9joy1_out  <= 6'h3F;
            db9joy2_out  <= 6'h3F;
            frame_done   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    joy_load_n <= 1'b1;
                    joy_clk    <= 1'b0;
                    if (w_tick && enable) begin
                        r_state    <= S_LOAD;
                        joy_load_n <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (w_tick) begin
                        r_state    <= S_SAMPLE;
                        joy_load_n <= 1'b1;
                        r_bit_cnt  <= 4'd0;
                    end
                end
                S_SAMPLE: begin
                    if (w_tick) begin
                        r_shift <= {r_shift[14:0], w_data_s};
                        r_state <= S_CLKHI;
                        joy_clk <= 1'b1;
                    end
                end
                S_CLKHI: begin
                    if (w_tick) begin
                        joy_clk <= 1'b0;
                        if (r_bit_cnt == c_BIT_LAST) begin
                            r_state    <= S_UPDATE;
                            frame_done <= 1'b1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            r_state   <= S_SAMPLE;
                        end
                    end
                end
                S_UPDATE: begin
                    // Publish only when the frame repeats; always remember it
                    if (w_frame == r_prev_frame) begin
                        db9joy1_out <= w_frame[11:6];
                        db9joy2_out <= w_frame[5:0];
                    end
                    r_prev_frame <= w_frame;
                    r_state      <= S_IDLE;
                    busy         <= 1'b0;
                end
                default: begin
                    r_state    <= S_IDLE;
                    joy_load_n <= 1'b1;
                    joy_clk    <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_joy_serial_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_joy_serial_scanner
// Description : Directed bench for joy_serial_scanner at CLKDIV=8 and 4,
//               with a behavioural model of the external shift register.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_joy_serial_scanner;

    localparam logic [15:0] c_PAT_A = 16'b101110_11_011111_11; // j1=2E j2=1F
    localparam logic [15:0] c_PAT_G = 16'b010101_11_101010_11; // j1=15 j2=2A
    localparam logic [15:0] c_PAT_H = 16'b110101_11_101010_11; // G, bit 15 flipped

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic enable8 = 1'b0;
    logic enable4 = 1'b0;

    logic       data8, load8, jclk8, fd8, busy8;
    logic [5:0] j1_8, j2_8;
    logic       data4, load4, jclk4, fd4, busy4;
    logic [5:0] j1_4, j2_4;

    logic [15:0] pat8 = 16'hFFFF;
    logic [15:0] pat4 = 16'hFFFF;
    logic [15:0] sr8  = 16'hFFFF;
    logic [15:0] sr4  = 16'hFFFF;
    logic        jcd8 = 1'b0;
    logic        jcd4 = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    joy_serial_scanner #(.CLKDIV(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .enable(enable8), .joy_data(data8),
        .joy_load_n(load8), .joy_clk(jclk8), .db9joy1_out(j1_8),
        .db9joy2_out(j2_8), .frame_done(fd8), .busy(busy8)
    );

    joy_serial_scanner #(.CLKDIV(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .enable(enable4), .joy_data(data4),
        .joy_load_n(load4), .joy_clk(jclk4), .db9joy1_out(j1_4),
        .db9joy2_out(j2_4), .frame_done(fd4), .busy(busy4)
    );

    // External 16-bit PISO register models: load while strobe low, shift on joy_clk rise
    always @(posedge clk) begin
        if (!load8) sr8 <= pat8;
        else if (jclk8 && !jcd8) sr8 <= {sr8[14:0], 1'b1};
        jcd8 <= jclk8;
        if (!load4) sr4 <= pat4;
        else if (jclk4 && !jcd4) sr4 <= {sr4[14:0], 1'b1};
        jcd4 <= jclk4;
    end
    assign data8 = sr8[15];
    assign data4 = sr4[15];

    // Observe one frame: idle negedges before LOAD (incl. first LOAD one),
    // LOAD->frame_done length, load-low count, joy_clk rising edges
    task automatic wait_frame(input bit sel, output int pre, output int len,
                              output int lo, output int rises, output bit ok);
        bit started = 0;
        bit pjc, jl, jc, fd;
        pre = 0; len = 0; lo = 0; rises = 0; ok = 0;
        pjc = sel ? jclk4 : jclk8;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            jl = sel ? load4 : load8;
            jc = sel ? jclk4 : jclk8;
            fd = sel ? fd4 : fd8;
            if (started) len++;
            if (!jl) begin
                started = 1;
                lo++;
            end
            if (!started) pre++;
            else if (len == 0 && !jl) pre++;
            if (started && jc && !pjc) rises++;
            pjc = jc;
            if (fd) begin
                ok = started;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int bad = 0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (load8 !== 1'b1) begin errors++; $display("FAIL reset_load_n got=%b exp=1", load8); end
        checks++; if (jclk8 !== 1'b0) begin errors++; $display("FAIL reset_joy_clk got=%b exp=0", jclk8); end
        checks++; if (j1_8 !== 6'h3F) begin errors++; $display("FAIL reset_joy1 got=%h exp=3f", j1_8); end
        checks++; if (j2_8 !== 6'h3F) begin errors++; $display("FAIL reset_joy2 got=%h exp=3f", j2_8); end
        checks++; if (fd8 !== 1'b0 || busy8 !== 1'b0) begin errors++; $display("FAIL reset_fd_busy got=%b%b exp=00", fd8, busy8); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (load8 !== 1'b1 || jclk8 !== 1'b0 || busy8 !== 1'b0 || fd8 !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL idle_quiet got=%0d bad cycles exp=0", bad); end
        checks++; if (j1_8 !== 6'h3F || j2_8 !== 6'h3F) begin errors++; $display("FAIL idle_outputs got=%h/%h exp=3f/3f", j1_8, j2_8); end
    endtask

    task automatic test_frame();
        int pre, len, lo, rises; bit ok;
        pat8 = c_PAT_A;
        enable8 = 1'b1;
        wait_frame(0, pre, len, lo, rises, ok);
        checks++; if (!ok) begin errors++; $display("FAIL frame1_timeout got=none exp=frame_done"); end
        checks++; if (len !== 264) begin errors++; $display("FAIL frame_len got=%0d exp=264", len); end
        checks++; if (lo !== 8) begin errors++; $display("FAIL load_low got=%0d exp=8", lo); end
        checks++; if (rises !== 16) begin errors++; $display("FAIL joy_clk_edges got=%0d exp=16", rises); end
        repeat (2) @(negedge clk);
        checks++; if (j1_8 !== 6'h3F || j2_8 !== 6'h3F) begin errors++; $display("FAIL frame1_outputs got=%h/%h exp=3f/3f", j1_8, j2_8); end
        wait_frame(0, pre, len, lo, rises, ok);
        pat8 = c_PAT_G;
        repeat (2) @(negedge clk);
        checks++; if (!ok || j1_8 !== 6'h2E || j2_8 !== 6'h1F) begin errors++; $display("FAIL frame2_outputs got=%h/%h exp=2e/1f", j1_8, j2_8); end
    endtask

    task automatic test_glitch();
        int pre, len, lo, rises; bit ok;
        // frame G (prev = A): no update
        wait_frame(0, pre, len, lo, rises, ok);
        pat8 = c_PAT_H;
        repeat (2) @(negedge clk);
        checks++; if (!ok || j1_8 !== 6'h2E || j2_8 !== 6'h1F) begin errors++; $display("FAIL glitch_G got=%h/%h exp=2e/1f", j1_8, j2_8); end
        // frame H (one bit differs): no update
        wait_frame(0, pre, len, lo, rises, ok);
        pat8 = c_PAT_G;
        repeat (2) @(negedge clk);
        checks++; if (!ok || j1_8 !== 6'h2E || j2_8 !== 6'h1F) begin errors++; $display("FAIL glitch_H got=%h/%h exp=2e/1f", j1_8, j2_8); end
        // frame G after H: still no update
        wait_frame(0, pre, len, lo, rises, ok);
        repeat (2) @(negedge clk);
        checks++; if (!ok || j1_8 !== 6'h2E || j2_8 !== 6'h1F) begin errors++; $display("FAIL glitch_GH got=%h/%h exp=2e/1f", j1_8, j2_8); end
        // second consecutive G: update
        wait_frame(0, pre, len, lo, rises, ok);
        repeat (2) @(negedge clk);
        checks++; if (!ok || j1_8 !== 6'h15 || j2_8 !== 6'h2A) begin errors++; $display("FAIL glitch_GG got=%h/%h exp=15/2a", j1_8, j2_8); end
    endtask

    task automatic test_enable_drop();
        int rises = 0, fds = 0, extra_fd = 0, loads = 0, busy_hi = 0;
        bit pjc = jclk8, started = 0, seen = 0, busy_upd = 0, busy_after = 1;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (!load8) started = 1;
            if (started && jclk8 && !pjc) rises++;
            pjc = jclk8;
            if (rises == 6) enable8 = 1'b0;
            if (fd8) begin
                seen = 1;
                busy_upd = busy8;
                break;
            end
        end
        checks++; if (!seen || enable8 !== 1'b0) begin errors++; $display("FAIL drop_complete got=%b exp=1", seen); end
        checks++; if (busy_upd !== 1'b1) begin errors++; $display("FAIL drop_busy_upd got=%b exp=1", busy_upd); end
        @(negedge clk);
        busy_after = busy8;
        checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL drop_busy_fall got=%b exp=0", busy_after); end
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (fd8) extra_fd++;
            if (!load8) loads++;
            if (busy8) busy_hi++;
        end
        checks++; if (extra_fd !== 0 || loads !== 0 || busy_hi !== 0) begin errors++; $display("FAIL drop_no_restart got=fd%0d/load%0d/busy%0d exp=0/0/0", extra_fd, loads, busy_hi); end
        checks++; if (j1_8 !== 6'h15 || j2_8 !== 6'h2A) begin errors++; $display("FAIL drop_outputs got=%h/%h exp=15/2a", j1_8, j2_8); end
    endtask

    task automatic test_reset_mid();
        int rises = 0, pre, len, lo, r; bit pjc = jclk8, started = 0, hit = 0, ok;
        enable8 = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (!load8) started = 1;
            if (started && jclk8 && !pjc) rises++;
            pjc = jclk8;
            if (rises == 10 && jclk8) begin
                hit = 1;
                break;
            end
        end
        checks++; if (!hit) begin errors++; $display("FAIL midreset_reach got=0 exp=1"); end
        rst_n = 1'b0;
        #1;
        checks++; if (jclk8 !== 1'b0 || load8 !== 1'b1 || busy8 !== 1'b0) begin errors++; $display("FAIL midreset_ctrl got=%b%b%b exp=010", jclk8, load8, busy8); end
        checks++; if (j1_8 !== 6'h3F || j2_8 !== 6'h3F) begin errors++; $display("FAIL midreset_outputs got=%h/%h exp=3f/3f", j1_8, j2_8); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_frame(0, pre, len, lo, r, ok);
        checks++; if (!ok || len !== 264 || lo !== 8 || r !== 16) begin errors++; $display("FAIL midreset_next got=len%0d lo%0d edges%0d exp=264/8/16", len, lo, r); end
        repeat (2) @(negedge clk);
        checks++; if (j1_8 !== 6'h3F || j2_8 !== 6'h3F) begin errors++; $display("FAIL midreset_filter got=%h/%h exp=3f/3f", j1_8, j2_8); end
        enable8 = 1'b0;
    endtask

    task automatic test_clkdiv4();
        int pre, len, lo, rises; bit ok;
        pat4 = c_PAT_A;
        enable4 = 1'b1;
        wait_frame(1, pre, len, lo, rises, ok);
        checks++; if (!ok || len !== 132) begin errors++; $display("FAIL div4_len got=%0d exp=132", len); end
        checks++; if (lo !== 4 || rises !== 16) begin errors++; $display("FAIL div4_shape got=lo%0d edges%0d exp=4/16", lo, rises); end
        wait_frame(1, pre, len, lo, rises, ok);
        repeat (2) @(negedge clk);
        checks++; if (!ok || j1_4 !== 6'h2E || j2_4 !== 6'h1F) begin errors++; $display("FAIL div4_data got=%h/%h exp=2e/1f", j1_4, j2_4); end
    endtask

    task automatic test_back_to_back();
        int pre, len, lo, rises; bit ok;
        pat4 = c_PAT_G;
        wait_frame(1, pre, len, lo, rises, ok);
        wait_frame(1, pre, len, lo, rises, ok);
        checks++; if (!ok || pre !== 4) begin errors++; $display("FAIL b2b_gap got=%0d exp=4", pre); end
        checks++; if (pre + len !== 136) begin errors++; $display("FAIL b2b_period got=%0d exp=136", pre + len); end
        repeat (2) @(negedge clk);
        checks++; if (j1_4 !== 6'h15 || j2_4 !== 6'h2A) begin errors++; $display("FAIL b2b_data got=%h/%h exp=15/2a", j1_4, j2_4); end
        enable4 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_frame();
        test_glitch();
        test_enable_drop();
        test_reset_mid();
        test_clkdiv4();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/joy_serial_scanner.md
JOY_SERIAL_SCANNER -- requirements
Module: joy_serial_scanner

Interface
REQ-001 SHALL have parameter CLKDIV, default 8, meaning clk cycles per half-period of joy_clk and per load pulse; legal range 4..255.
REQ-002 SHALL have ports clk  in  1  system clock, all logic on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset; one clock, reset asynchronous and active-low.
REQ-004 SHALL have port enable  in  1  1 = start a new scan frame from IDLE; sampled only in IDLE.
REQ-005 SHALL have port joy_data  in  1  serial data from external 16-bit parallel-in shift register, active-low (0 = pressed).
REQ-006 SHALL have port joy_load_n  out  1  parallel-load strobe to shift register, active-low.
REQ-007 SHALL have port joy_clk  out  1  shift clock to shift register, shifts on its rising edge.
REQ-008 SHALL have port db9joy1_out  out  6  joystick 1 state {F2,F1,U,D,L,R}, 0 = pressed.
REQ-009 SHALL have port db9joy2_out  out  6  joystick 2 state, same format.
REQ-010 SHALL have port frame_done  out  1  one-clk pulse per completed frame.
REQ-011 SHALL have port busy  out  1  1 whenever state is not IDLE.

Function
REQ-012 SHALL synchronise joy_data through two flip-flops; all sampling uses the synchronised value.
REQ-013 SHALL run a free-running tick counter 0..CLKDIV-1; tick asserted for one clk when counter = CLKDIV-1, then wraps to 0.
REQ-014 SHALL implement FSM states IDLE, LOAD, SAMPLE, CLKHI, UPDATE; all transitions except UPDATE->IDLE occur only on tick.
REQ-015 IDLE: joy_load_n=1, joy_clk=0; on tick with enable=1 -> LOAD; else stay.
REQ-016 LOAD: joy_load_n=0 for exactly CLKDIV clks; on tick -> SAMPLE, bit counter cleared to 0.
REQ-017 SAMPLE: joy_load_n=1, joy_clk=0; on tick shift synchronised bit into 16-bit register, MSB first ({sh[14:0],bit}), -> CLKHI.
REQ-018 CLKHI: joy_clk=1; on tick, if bit counter = 15 -> UPDATE, else increment counter -> SAMPLE.
REQ-019 UPDATE: lasts exactly one clk, frame_done=1, -> IDLE unconditionally.
REQ-020 Frame mapping: sh[15:10] = joystick 1 {F2,F1,U,D,L,R}; sh[7:2] = joystick 2; sh[9:8], sh[1:0] ignored.
REQ-021 Glitch filter: in UPDATE, outputs load the new frame only if its 12 used bits equal the previous captured frame; the new frame always becomes the previous frame.
REQ-022 Frame length from entering LOAD to UPDATE SHALL be 33*CLKDIV clks (264 at CLKDIV=8); joy_clk produces exactly 16 rising edges per frame.
REQ-023 enable deasserted mid-frame SHALL NOT abort the frame; it completes and FSM rests in IDLE.
REQ-024 enable held high SHALL give continuous back-to-back frames, each starting at the first tick after UPDATE.
REQ-025 Outputs db9joy*_out, joy_load_n, joy_clk, frame_done, busy SHALL be registered (no combinational path from joy_data or enable).

Reset
REQ-026 On rst_n=0, immediately: state IDLE, tick counter 0, bit counter 0, shift register 16'hFFFF, previous frame all ones, synchroniser ones.
REQ-027 On rst_n=0, immediately: joy_load_n=1, joy_clk=0, db9joy1_out=6'h3F, db9joy2_out=6'h3F, frame_done=0, busy=0.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame; outputs return to REQ-027 values.

Verification
REQ-029 Reset released, enable=0 for 1000 clks -> joy_load_n=1, joy_clk=0, busy=0, outputs 6'h3F, no frame_done.
REQ-030 CLKDIV=8, enable=1, model drives 16'b101110_11_011111_11 twice -> after second frame_done db9joy1_out=6'h2E, db9joy2_out=6'h1F; first frame leaves outputs 6'h3F; joy_load_n low 8 clks; 16 joy_clk edges; frame 264 clks.
REQ-031 Glitch: frames A, B(one bit differs), A -> outputs unchanged after B and after the following A; a second consecutive A updates them.
REQ-032 enable dropped at bit 5 of a frame -> frame completes, frame_done pulses once, busy falls the clk after UPDATE, no further LOAD.
REQ-033 rst_n pulsed low during bit 9 -> joy_clk=0, joy_load_n=1, outputs 6'h3F same cycle; after release next frame starts cleanly from LOAD.
REQ-034 CLKDIV=4, continuous scan -> frame length 132 clks, data sampled correctly with two-flop synchroniser latency.
